pipeline_ctrl: RTL and testbench

Hazard and sequencing controller for the five-stage pipeline. It drives the enable/flush pins of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves:
- instruction- and data-memory wait stalls
- load-use hazards
- taken branch/jump redirects
- the halt drain sequence

It also keeps saturating performance counters for the system testbench.

---
 rtl/cpu_types_pkg.sv | 10 +
 rtl/pctrl_if.sv | 31 +++
 rtl/sat_counter.sv | 20 ++
 rtl/pipeline_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 172 +++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
package cpu_types_pkg;
  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } pctrl_state_t;
endpackage

// File: rtl/pctrl_if.sv
// Bundle of pipeline_ctrl signals, with a DUT view and a stimulus view.
interface pctrl_if #(
  parameter int CNT_W = 16
) (
  input logic CLK
);
  import cpu_types_pkg::*;

  logic             RST;
  logic             ihit, dhit;
  logic [REG_W-1:0] ifid_rs, ifid_rt, idex_rt;
  logic             ifid_uses_rt, idex_dren, idex_halt, ex_redirect;
  logic             exmem_dren, exmem_dwen, memwb_halt;
  logic             pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic             ifid_flush, idex_flush, exmem_flush, halt;
  logic [CNT_W-1:0] cyc_cnt, stall_cnt, flush_cnt;

  modport pctrl (
    input  CLK, RST, ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dren, idex_rt,
           idex_halt, ex_redirect, exmem_dren, exmem_dwen, memwb_halt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           exmem_flush, halt, cyc_cnt, stall_cnt, flush_cnt
  );

  modport tb (
    input  CLK, pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
           exmem_flush, halt, cyc_cnt, stall_cnt, flush_cnt,
    output RST, ihit, dhit, ifid_rs, ifid_rt, ifid_uses_rt, idex_dren, idex_rt,
           idex_halt, ex_redirect, exmem_dren, exmem_dwen, memwb_halt
  );
endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; clr wins over inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);
  logic [W-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (clr)
      count_reg <= '0;
    else if (inc && (count_reg != {W{1'b1}}))
      count_reg <= count_reg + W'(1);
  end

  assign count = count_reg;
endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/enable controller for the five-stage pipeline, with halt drain
// sequencing and saturating performance counters.
module pipeline_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic [REG_W-1:0] ifid_rs,
  input  logic [REG_W-1:0] ifid_rt,
  input  logic             ifid_uses_rt,
  input  logic             idex_dren,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             idex_halt,
  input  logic             ex_redirect,
  input  logic             exmem_dren,
  input  logic             exmem_dwen,
  input  logic             memwb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             halt,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  pctrl_state_t state_reg, state_next;
  logic         halt_reg;
  logic         dmem_stall, load_use, stall_ev, flush_ev;
  logic [2:0]   cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign dmem_stall = (exmem_dren | exmem_dwen) & ~dhit;
  assign load_use   = idex_dren & (idex_rt != '0) &
                      ((idex_rt == ifid_rs) | (ifid_uses_rt & (idex_rt == ifid_rt)));

  // Priority chain: the first matching rule owns every output it does not set to 0.
  always_comb begin
    pc_en       = 1'b0;
    ifid_en     = 1'b0;
    idex_en     = 1'b0;
    exmem_en    = 1'b0;
    memwb_en    = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    stall_ev    = 1'b0;
    flush_ev    = 1'b0;
    if (state_reg == HALTED) begin
    end else if (dmem_stall) begin
      stall_ev = 1'b1;
    end else if (state_reg == DRAIN) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
    end else if (!ihit) begin
      exmem_flush = 1'b1;
      memwb_en    = 1'b1;
      stall_ev    = 1'b1;
    end else if (ex_redirect) begin
      pc_en      = 1'b1;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      flush_ev   = 1'b1;
    end else if (load_use) begin
      idex_flush = 1'b1;
      exmem_en   = 1'b1;
      memwb_en   = 1'b1;
      stall_ev   = 1'b1;
    end else begin
      pc_en    = 1'b1;
      ifid_en  = 1'b1;
      idex_en  = 1'b1;
      exmem_en = 1'b1;
      memwb_en = 1'b1;
    end
  end

  // The halt only leaves RUN once it actually moves out of EX.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (idex_halt && exmem_en) state_next = DRAIN;
      DRAIN:   if (memwb_halt) state_next = HALTED;
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg <= RUN;
      halt_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == DRAIN) && memwb_halt)
        halt_reg <= 1'b1;
    end
  end

  assign halt    = halt_reg;
  assign cnt_inc = {flush_ev, stall_ev, state_reg != HALTED};

  for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
    sat_counter #(.W(CNT_W)) u_cnt (
      .clk   (CLK),
      .clr   (RST),
      .inc   (cnt_inc[gi]),
      .count (cnt_val[gi])
    );
  end

  assign cyc_cnt   = cnt_val[0];
  assign stall_cnt = cnt_val[1];
  assign flush_cnt = cnt_val[2];
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed vectors push expectations, a
// negedge monitor pops and compares; a 4-bit-counter copy checks saturation.
module tb_pipeline_ctrl;
  localparam logic [7:0] ALL = 8'hF8;
  localparam logic [7:0] LU  = 8'h1A;
  localparam logic [7:0] RD  = 8'h9E;
  localparam logic [7:0] IM  = 8'h09;
  localparam logic [7:0] DR  = 8'h1E;
  localparam logic [7:0] ZR  = 8'h00;

  typedef struct {
    logic [7:0]  ctl;
    logic        halt;
    logic [15:0] cyc, stall, flush;
    logic [3:0]  s_cyc, s_stall;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  pctrl_if #(.CNT_W(16)) bus (.CLK(clk));

  logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
  logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halt;
  logic [3:0]  s_cyc_cnt, s_stall_cnt, s_flush_cnt;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_txn = 0;

  pipeline_ctrl #(.CNT_W(16)) dut (
    .CLK(clk), .RST(bus.RST), .ihit(bus.ihit), .dhit(bus.dhit),
    .ifid_rs(bus.ifid_rs), .ifid_rt(bus.ifid_rt), .ifid_uses_rt(bus.ifid_uses_rt),
    .idex_dren(bus.idex_dren), .idex_rt(bus.idex_rt), .idex_halt(bus.idex_halt),
    .ex_redirect(bus.ex_redirect), .exmem_dren(bus.exmem_dren),
    .exmem_dwen(bus.exmem_dwen), .memwb_halt(bus.memwb_halt),
    .pc_en(bus.pc_en), .ifid_en(bus.ifid_en), .idex_en(bus.idex_en),
    .exmem_en(bus.exmem_en), .memwb_en(bus.memwb_en), .ifid_flush(bus.ifid_flush),
    .idex_flush(bus.idex_flush), .exmem_flush(bus.exmem_flush), .halt(bus.halt),
    .cyc_cnt(bus.cyc_cnt), .stall_cnt(bus.stall_cnt), .flush_cnt(bus.flush_cnt)
  );

  pipeline_ctrl #(.CNT_W(4)) dut_sat (
    .CLK(clk), .RST(bus.RST), .ihit(bus.ihit), .dhit(bus.dhit),
    .ifid_rs(bus.ifid_rs), .ifid_rt(bus.ifid_rt), .ifid_uses_rt(bus.ifid_uses_rt),
    .idex_dren(bus.idex_dren), .idex_rt(bus.idex_rt), .idex_halt(bus.idex_halt),
    .ex_redirect(bus.ex_redirect), .exmem_dren(bus.exmem_dren),
    .exmem_dwen(bus.exmem_dwen), .memwb_halt(bus.memwb_halt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
    .exmem_en(s_exmem_en), .memwb_en(s_memwb_en), .ifid_flush(s_ifid_flush),
    .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush), .halt(s_halt),
    .cyc_cnt(s_cyc_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  function automatic logic [3:0] sat4(input int v);
    return (v > 15) ? 4'd15 : 4'(v);
  endfunction

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL txn %0d %s: got %0h expected %0h", n_txn, nm, act, req);
    end
  endtask

  task automatic set_idle();
    bus.RST = 1'b0;         bus.ihit = 1'b1;        bus.dhit = 1'b0;
    bus.ifid_rs = '0;       bus.ifid_rt = '0;       bus.ifid_uses_rt = 1'b0;
    bus.idex_dren = 1'b0;   bus.idex_rt = '0;       bus.idex_halt = 1'b0;
    bus.ex_redirect = 1'b0; bus.exmem_dren = 1'b0;  bus.exmem_dwen = 1'b0;
    bus.memwb_halt = 1'b0;
  endtask

  task automatic set_load_use();
    bus.idex_dren = 1'b1; bus.idex_rt = 5'd5; bus.ifid_rs = 5'd5;
  endtask

  // Push the expectation for the current cycle, then advance one clock.
  task automatic step(input logic [7:0] ctl, input logic h, input int c, input int s,
                      input int f);
    exp_t e;
    e.ctl = ctl; e.halt = h;
    e.cyc = 16'(c); e.stall = 16'(s); e.flush = 16'(f);
    e.s_cyc = sat4(c); e.s_stall = sat4(s);
    exp_q.push_back(e);
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      logic [7:0] act;
      e = exp_q.pop_front();
      n_txn++;
      act = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
             bus.ifid_flush, bus.idex_flush, bus.exmem_flush};
      chk("ctl", int'(act), int'(e.ctl));
      chk("halt", int'(bus.halt), int'(e.halt));
      chk("cyc_cnt", int'(bus.cyc_cnt), int'(e.cyc));
      chk("stall_cnt", int'(bus.stall_cnt), int'(e.stall));
      chk("flush_cnt", int'(bus.flush_cnt), int'(e.flush));
      chk("sat_cyc_cnt", int'(s_cyc_cnt), int'(e.s_cyc));
      chk("sat_stall_cnt", int'(s_stall_cnt), int'(e.s_stall));
      $display("txn %0d ctl=%02h halt=%0b cyc=%0d stall=%0d flush=%0d sat_stall=%0d",
               n_txn, act, bus.halt, bus.cyc_cnt, bus.stall_cnt, bus.flush_cnt,
               s_stall_cnt);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    set_idle();
    bus.RST = 1'b1;
    @(posedge clk); #1;

    set_idle();                                    step(ALL, 0, 0, 0, 0);
    set_idle(); set_load_use();                    step(LU,  0, 1, 0, 0);
    set_idle();                                    step(ALL, 0, 2, 1, 0);
    set_idle(); bus.idex_dren = 1; bus.idex_rt = 7; bus.ifid_rs = 3; bus.ifid_rt = 7;
                                                   step(ALL, 0, 3, 1, 0);
    bus.ifid_uses_rt = 1;                          step(LU,  0, 4, 1, 0);
    set_idle(); bus.idex_dren = 1;                 step(ALL, 0, 5, 2, 0);
    set_idle(); set_load_use(); bus.ex_redirect = 1;
                                                   step(RD,  0, 6, 2, 0);
    set_idle();                                    step(ALL, 0, 7, 2, 1);
    set_idle(); bus.ex_redirect = 1; bus.ihit = 0; step(IM,  0, 8, 2, 1);
    bus.ihit = 1;                                  step(RD,  0, 9, 3, 1);
    set_idle();                                    step(ALL, 0, 10, 3, 2);
    set_idle(); bus.exmem_dwen = 1; bus.ihit = 0;
    for (int i = 0; i < 3; i++)                    step(ZR,  0, 11 + i, 3 + i, 2);
    bus.dhit = 1;                                  step(IM,  0, 14, 6, 2);
    set_idle(); bus.ihit = 0;                      step(IM,  0, 15, 7, 2);
    set_idle();                                    step(ALL, 0, 16, 8, 2);
    set_idle(); bus.exmem_dren = 1; bus.ex_redirect = 1;
                                                   step(ZR,  0, 17, 8, 2);
    bus.dhit = 1;                                  step(RD,  0, 18, 9, 2);
    set_idle(); bus.idex_halt = 1; bus.exmem_dren = 1;
                                                   step(ZR,  0, 19, 9, 3);
    bus.dhit = 1;                                  step(ALL, 0, 20, 10, 3);
    set_idle(); set_load_use(); bus.ex_redirect = 1; bus.ihit = 0;
                                                   step(DR,  0, 21, 10, 3);
    set_idle(); bus.memwb_halt = 1;                step(DR,  0, 22, 10, 3);
    set_idle();                                    step(ZR,  1, 23, 10, 3);
    set_idle(); set_load_use(); bus.exmem_dren = 1;
                                                   step(ZR,  1, 23, 10, 3);
                                                   step(ZR,  1, 23, 10, 3);
    set_idle(); bus.RST = 1;
    @(posedge clk); #1;
    set_idle();                                    step(ALL, 0, 0, 0, 0);
    set_idle(); set_load_use(); bus.RST = 1;       step(LU,  0, 1, 0, 0);
    set_idle();                                    step(ALL, 0, 0, 0, 0);
    set_idle(); bus.exmem_dwen = 1;
    for (int i = 1; i <= 20; i++)                  step(ZR,  0, i, i - 1, 0);
    set_idle();                                    step(ALL, 0, 21, 20, 0);

    @(posedge clk); #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
